// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: valid/ready on both sides, 2-entry skid buffer,
// synchronous flush and a saturating back-pressure (stall) counter.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W        = 32,
  parameter logic [DATA_W-1:0] RESET_VAL     = '0,
  parameter bit                ZERO_ON_FLUSH = 1'b1,
  parameter int unsigned       CNT_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              stall_clr_i
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_fire;
  logic              out_fire;

  // Handshake outputs are pure state decodes, so neither depends on any input.
  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q == BUSY) || (state_q == FULL);
  assign out_data_o  = main_q;
  assign stall_cnt_o = stall_cnt_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    occupancy_o = 2'd0;
    case (state_q)
      BUSY:    occupancy_o = 2'd1;
      FULL:    occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Anything accepted or presented this cycle is squashed.
      state_d = EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_d = RESET_VAL;
        skid_d = RESET_VAL;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            main_d  = in_data_i;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr_i) begin
      stall_cnt_d = '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed checks of pipe_stage_buf on two configurations sharing one stimulus,
// followed by a randomised run of the 64-bit instance against a FIFO scoreboard.
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic        stall_clr;
  logic [63:0] in_data;

  // Instance A: 64-bit, flush zeroes payload, 4-bit counter
  logic        a_in_ready, a_out_valid;
  logic [63:0] a_out_data;
  logic [1:0]  a_occ;
  logic [3:0]  a_cnt;

  // Instance B: 32-bit, flush keeps payload, 16-bit counter
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_occ;
  logic [15:0] b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_buf #(
    .DATA_W(64), .RESET_VAL(64'd0), .ZERO_ON_FLUSH(1'b1), .CNT_W(4)
  ) dut_a (
    .clock(clk), .reset(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
    .occupancy_o(a_occ), .stall_cnt_o(a_cnt), .stall_clr_i(stall_clr)
  );

  pipe_stage_buf #(
    .DATA_W(32), .RESET_VAL(32'd0), .ZERO_ON_FLUSH(1'b0), .CNT_W(16)
  ) dut_b (
    .clock(clk), .reset(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data[31:0]),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
    .occupancy_o(b_occ), .stall_cnt_o(b_cnt), .stall_clr_i(stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic r, input logic [1:0] occ,
                       input logic [63:0] d);
    check({tag, "_a_valid"}, a_out_valid, v);
    check({tag, "_a_ready"}, a_in_ready, r);
    check({tag, "_a_occ"}, a_occ, occ);
    check({tag, "_a_data"}, a_out_data, d);
  endtask

  task automatic chk_b(input string tag, input logic v, input logic r, input logic [1:0] occ,
                       input logic [63:0] d);
    check({tag, "_b_valid"}, b_out_valid, v);
    check({tag, "_b_ready"}, b_in_ready, r);
    check({tag, "_b_occ"}, b_occ, occ);
    check({tag, "_b_data"}, b_out_data, d);
  endtask

  logic [63:0] sb_q[$];
  logic [63:0] exp_word;
  logic [63:0] prev_data;
  logic        prev_hold;
  logic        a_in_fire, a_out_fire;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    stall_clr = 1'b0; in_data = 64'hDEADBEEF;

    // Reset held with valid input present
    tick(); tick();
    chk_a("rst", 1'b0, 1'b1, 2'd0, 64'd0);
    chk_b("rst", 1'b0, 1'b1, 2'd0, 64'd0);
    check("rst_a_cnt", a_cnt, 64'd0);
    check("rst_b_cnt", b_cnt, 64'd0);

    // First word after reset release appears one cycle later
    rst_n = 1'b1; out_ready = 1'b1; in_data = 64'h11;
    tick();
    chk_a("first", 1'b1, 1'b1, 2'd1, 64'h11);
    chk_b("first", 1'b1, 1'b1, 2'd1, 64'h11);

    // Full throughput streaming
    for (int k = 1; k <= 4; k++) begin
      in_data = 64'(k);
      tick();
      chk_a($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1, 64'(k));
      chk_b($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1, 64'(k));
    end
    in_valid = 1'b0;
    tick();
    chk_a("drain", 1'b0, 1'b1, 2'd0, 64'd4);
    check("drain_a_cnt", a_cnt, 64'd0);

    // Back-pressure into the skid entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
    tick();
    chk_a("bp_busy", 1'b1, 1'b1, 2'd1, 64'hA);
    check("bp_busy_a_cnt", a_cnt, 64'd0);
    in_data = 64'hB;
    tick();
    chk_a("bp_full", 1'b1, 1'b0, 2'd2, 64'hA);
    chk_b("bp_full", 1'b1, 1'b0, 2'd2, 64'hA);
    in_data = 64'hC;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp_hold_a_data", a_out_data, 64'hA);
    end
    chk_a("bp_held", 1'b1, 1'b0, 2'd2, 64'hA);
    check("bp_a_cnt5", a_cnt, 64'd5);
    check("bp_b_cnt5", b_cnt, 64'd5);

    // Release: A was on the bus, B follows, then empty
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_a("rel_b", 1'b1, 1'b1, 2'd1, 64'hB);
    check("rel_a_cnt", a_cnt, 64'd5);
    tick();
    chk_a("rel_empty", 1'b0, 1'b1, 2'd0, 64'hB);
    chk_b("rel_empty", 1'b0, 1'b1, 2'd0, 64'hB);

    // Refill to FULL with A/B, then flush with a new word offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
    tick();
    in_data = 64'hB;
    tick();
    chk_a("pre_flush", 1'b1, 1'b0, 2'd2, 64'hA);
    in_data = 64'hC; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_a("flush", 1'b0, 1'b1, 2'd0, 64'd0);
    chk_b("flush", 1'b0, 1'b1, 2'd0, 64'hA);
    check("flush_a_cnt", a_cnt, 64'd7);
    check("flush_b_cnt", b_cnt, 64'd7);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_flush_a_valid", a_out_valid, 1'b0);
      check("post_flush_b_valid", b_out_valid, 1'b0);
    end

    // Counter clear, saturation and clear-during-stall
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    check("clr_a_cnt", a_cnt, 64'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h55;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("sat_a_cnt", a_cnt, 64'd15);
    check("sat_b_cnt", b_cnt, 64'd20);
    tick();
    check("sat_hold_a_cnt", a_cnt, 64'd15);
    stall_clr = 1'b1;
    tick();
    check("clr_stall_a_cnt", a_cnt, 64'd0);
    check("clr_stall_b_cnt", b_cnt, 64'd0);
    stall_clr = 1'b0;
    tick();
    check("resume_a_cnt", a_cnt, 64'd1);
    check("resume_b_cnt", b_cnt, 64'd1);

    // Randomised run on instance A against a FIFO scoreboard
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb_q.delete();
    prev_hold = 1'b0;
    prev_data = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 5);
      in_data   = {$urandom, $urandom};
      check("rnd_ready_vs_occ", a_in_ready, (a_occ != 2'd2));
      check("rnd_occ", a_occ, 64'(sb_q.size()));
      a_in_fire  = in_valid & a_in_ready;
      a_out_fire = a_out_valid & out_ready;
      if (a_out_fire && !flush) begin
        if (sb_q.size() == 0) begin
          check("rnd_unexpected_word", 1'b1, 1'b0);
        end else begin
          exp_word = sb_q.pop_front();
          check("rnd_data", a_out_data, exp_word);
        end
      end
      if (flush) sb_q.delete();
      else if (a_in_fire) sb_q.push_back(in_data);
      prev_hold = a_out_valid & ~out_ready & ~flush;
      prev_data = a_out_data;
      tick();
      if (prev_hold) begin
        check("rnd_stall_valid", a_out_valid, 1'b1);
        check("rnd_stall_data", a_out_data, prev_data);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline stage register. It replaces the bare write-enable stage register between decode and execute, and between any other adjacent stages. It uses a valid/ready handshake on both sides with a 2-entry skid buffer, so throughput is one transfer per cycle while in_ready is driven from a flop. It also provides a synchronous flush for branch/trap squash and a saturating back-pressure counter for performance analysis.

Parameters:
DATA_W, 32, width of the packed payload (all stage fields concatenated by the instantiating stage)
RESET_VAL, 0, value loaded into both payload registers on reset (DATA_W bits)
ZERO_ON_FLUSH, 1, 1: flush also loads RESET_VAL into the payload registers; 0: payload registers keep their contents on flush
CNT_W, 16, width of the stall counter

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
flush_i  in  1  synchronous squash of all held entries
in_valid_i  in  1  upstream holds valid payload
in_ready_o  out  1  stage can accept; registered output
in_data_i  in  DATA_W  upstream payload
out_valid_o  out  1  stage presents valid payload
out_ready_i  in  1  downstream accepts
out_data_o  out  DATA_W  payload to downstream; always driven from the main register
occupancy_o  out  2  number of held entries (0..2)
stall_cnt_o  out  CNT_W  saturating count of cycles with out_valid_o=1 and out_ready_i=0
stall_clr_i  in  1  synchronous clear of stall_cnt_o

Behaviour:
- Definitions: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Reset (reset==0 at a clock edge): state=EMPTY; main and skid registers = RESET_VAL; stall_cnt=0.
  - Outputs during and after reset: in_ready_o=1, out_valid_o=0, out_data_o=RESET_VAL, occupancy_o=0.
  - Reset overrides flush and all other inputs.
- States, with the outputs decoded from state:
  - EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - BUSY: occupancy 1, out_valid 1, in_ready 1.
  - FULL: occupancy 2, out_valid 1, in_ready 0.
- Transitions when not reset and not flush:
  - EMPTY: in_fire -> BUSY, main<=in_data. Otherwise stay.
  - BUSY, in_fire & out_fire -> BUSY, main<=in_data.
  - BUSY, in_fire & !out_fire -> FULL, skid<=in_data; main unchanged.
  - BUSY, !in_fire & out_fire -> EMPTY.
  - BUSY, neither -> stay.
  - FULL: out_fire -> BUSY, main<=skid. Otherwise stay. No in_fire is possible in FULL.
- Latency: one cycle. Data accepted at edge N appears on out_data_o after edge N when the stage was EMPTY, or when it was BUSY with out_fire.
- Ordering: strictly FIFO. The skid entry is never presented before the main entry.
- Protocol rules:
  - out_data_o and out_valid_o stay stable while out_valid_o=1 and out_ready_i=0.
  - out_valid_o never depends combinationally on out_ready_i.
  - in_ready_o never depends combinationally on any input.
- Flush (flush_i=1, reset=1):
  - Next state is EMPTY regardless of handshakes.
  - Any in_fire or out_fire in the flush cycle is discarded; the upstream sees it as accepted and the data is dropped.
  - If ZERO_ON_FLUSH=1, main and skid load RESET_VAL.
  - stall_cnt is not affected by flush.
- Stall counter:
  - Increments by 1 on each cycle where out_valid_o=1 and out_ready_i=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - stall_clr_i=1 loads 0 and takes priority over increment.
  - Flush and stall in the same cycle still counts the stall.
- The payload registers have no X-propagation dependency: out_data_o is RESET_VAL or last loaded data even when out_valid_o=0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid_i=1, in_data_i=0xDEADBEEF -> in_ready_o=1, out_valid_o=0, out_data_o=0, occupancy_o=0, stall_cnt_o=0; release reset -> first accepted word appears one cycle later.
- Full throughput: out_ready_i=1, stream 0x1,0x2,0x3,0x4 on consecutive cycles -> out_data_o shows 0x1..0x4 on consecutive cycles starting one cycle after the first accept; occupancy_o stays 1; in_ready_o never drops.
- Back-pressure/skid:
  - Send 0xA then 0xB with out_ready_i=0 -> occupancy_o=2, in_ready_o=0, out_data_o=0xA stable.
  - Hold for 5 cycles -> stall_cnt_o=5 (counted from the first cycle out_valid_o=1).
  - Raise out_ready_i -> 0xA then 0xB delivered in order, then out_valid_o=0.
- Flush:
  - In FULL with 0xA/0xB held and in_valid_i=1, assert flush_i for 1 cycle -> next cycle out_valid_o=0, occupancy_o=0, out_data_o=0 (ZERO_ON_FLUSH=1).
  - Neither 0xA nor 0xB is ever delivered.
  - Rerun with ZERO_ON_FLUSH=0 -> out_data_o stays 0xA with out_valid_o=0.
- Counter saturation/clear:
  - CNT_W=4, hold a stall 20 cycles -> stall_cnt_o=15 and holds.
  - Pulse stall_clr_i during the stall -> stall_cnt_o=0, then resumes at 1 the next cycle.
- Random: constrained-random in_valid_i/out_ready_i/flush_i (flush at 5%), DATA_W=64, 10k cycles vs. scoreboard.
  - No loss or duplication outside flush-dropped words.
  - in_ready_o==(occupancy_o!=2) every cycle.
  - Payload stable under stall.
